// File: rtl/pwm_sample_dac_if.sv
// Code stream from the scaler into the PWM DAC: valid/ready handshake carrying one code per beat.
interface pwm_sample_dac_if #(
    parameter int CODE_WIDTH = 10
);
    logic [CODE_WIDTH-1:0] code;
    logic                  synth_valid;
    logic                  synth_ready;

    modport master (output code, output synth_valid, input synth_ready);
    modport slave  (input code, input synth_valid, output synth_ready);
endinterface

// File: rtl/pwm_sample_dac.sv
// PWM audio DAC: buffers up to two codes, loads one per 2**CODE_WIDTH-cycle period, holds on starvation.
// Optional saturating underrun counter enabled by defining PWM_DAC_UNDERRUN_CNT_EN.
module pwm_sample_dac #(
    parameter int CODE_WIDTH = 10,
    parameter int RESET_CODE = 512,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    pwm_sample_dac_if.slave       bus,
    output logic                  pwm_out,
    output logic                  period_start,
    output logic [1:0]            buf_level,
    output logic                  underrun,
    input  logic                  underrun_clr
`ifdef PWM_DAC_UNDERRUN_CNT_EN
    ,
    output logic [15:0]           underrun_cnt
`endif
);

    localparam logic [CODE_WIDTH-1:0] CNT_LAST   = '1;
    localparam logic [CODE_WIDTH-1:0] RST_CODE   = CODE_WIDTH'(RESET_CODE);
    localparam logic [1:0]            FULL_LEVEL = 2'(BUF_DEPTH);

    logic [CODE_WIDTH-1:0] cnt_q, cnt_d;
    logic [CODE_WIDTH-1:0] act_q, act_d;
    logic [CODE_WIDTH-1:0] head_q, head_d;
    logic [CODE_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            level_q, level_d;
    logic                  ready_q, ready_d;
    logic                  pwm_q, pwm_d;
    logic                  pstart_q, pstart_d;
    logic                  ur_q, ur_d;
    logic                  push, load, pop, starve;

    always_comb begin
        push   = bus.synth_valid && ready_q;
        load   = enable && (cnt_q == CNT_LAST);
        pop    = load && (level_q != 2'd0);
        starve = load && (level_q == 2'd0);

        cnt_d  = enable ? cnt_q + 1'b1 : '0;
        act_d  = pop ? head_q : act_q;

        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        case ({push, pop})
            2'b10: begin
                if (level_q == 2'd0) head_d = bus.code;
                else                 tail_d = bus.code;
                level_d = level_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                level_d = level_q - 2'd1;
            end
            // Push with pop only happens at level 1 (full blocks push), so the new code becomes head.
            2'b11: head_d = bus.code;
            default: ;
        endcase

        // Ready looks ahead to next-cycle occupancy so it stays a pure flop output.
        ready_d  = (level_d != FULL_LEVEL);
        pwm_d    = enable && (cnt_q < act_q);
        pstart_d = enable && (cnt_q == '0);
        ur_d     = starve ? 1'b1 : (underrun_clr ? 1'b0 : ur_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            act_q    <= RST_CODE;
            level_q  <= 2'd0;
            ready_q  <= 1'b0;
            pwm_q    <= 1'b0;
            pstart_q <= 1'b0;
            ur_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            act_q    <= act_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
            pwm_q    <= pwm_d;
            pstart_q <= pstart_d;
            ur_q     <= ur_d;
        end
    end

    // Buffer payload is qualified by level_q, so it needs no reset.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

`ifdef PWM_DAC_UNDERRUN_CNT_EN
    logic [15:0] urcnt_q, urcnt_d;

    always_comb begin
        if (starve && underrun_clr) urcnt_d = 16'd1;
        else if (starve)            urcnt_d = (urcnt_q == 16'hFFFF) ? urcnt_q : urcnt_q + 16'd1;
        else if (underrun_clr)      urcnt_d = '0;
        else                        urcnt_d = urcnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) urcnt_q <= '0;
        else        urcnt_q <= urcnt_d;
    end

    assign underrun_cnt = urcnt_q;
`endif

    assign bus.synth_ready = ready_q;
    assign pwm_out         = pwm_q;
    assign period_start    = pstart_q;
    assign buf_level       = level_q;
    assign underrun        = ur_q;

endmodule

// File: tb/tb_pwm_sample_dac.sv
// Directed/randomized bench for pwm_sample_dac with a period-level reference model (code queue + duty counts).
module tb_pwm_sample_dac;
    localparam int W = 10;
    localparam int P = 1 << W;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       underrun_clr = 1'b0;
    logic       pwm_out, period_start, underrun;
    logic [1:0] buf_level;
`ifdef PWM_DAC_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    pwm_sample_dac_if #(.CODE_WIDTH(W)) bus ();

    pwm_sample_dac #(.CODE_WIDTH(W), .RESET_CODE(512), .BUF_DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .bus          (bus),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .buf_level    (buf_level),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queued codes, code in force, sticky flag, starvation count, position in period.
    int fifo[$];
    int act;
    bit ur_exp;
    int urcnt_exp;
    int phase;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        fifo.delete();
        act       = 512;
        ur_exp    = 1'b0;
        urcnt_exp = 0;
        phase     = 0;
    endtask

    task automatic tick();
        bit en, ld, psh, clr, st, starve;
        int c;
        en     = enable;
        ld     = en && (phase == P - 1);
        psh    = bus.synth_valid && (fifo.size() < 2);
        c      = int'(bus.code);
        clr    = underrun_clr;
        st     = en && (phase == 0);
        starve = ld && (fifo.size() == 0);
        @(posedge clk);
        #1;
        if (ld && !starve) act = fifo.pop_front();
        if (psh) fifo.push_back(c);
        if (starve) ur_exp = 1'b1;
        else if (clr) ur_exp = 1'b0;
        if (starve && clr) urcnt_exp = 1;
        else if (starve) urcnt_exp = (urcnt_exp == 65535) ? 65535 : urcnt_exp + 1;
        else if (clr) urcnt_exp = 0;
        phase = en ? (phase + 1) % P : 0;
        check("period_start", period_start, st);
        check("buf_level", buf_level, fifo.size());
        check("synth_ready", bus.synth_ready, fifo.size() < 2);
        check("underrun", underrun, ur_exp);
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        check("underrun_cnt", underrun_cnt, urcnt_exp);
`endif
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_pwm_out", pwm_out, 0);
        check("rst_period_start", period_start, 0);
        check("rst_buf_level", buf_level, 0);
        check("rst_underrun", underrun, 0);
        check("rst_synth_ready", bus.synth_ready, 0);
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        check("rst_underrun_cnt", underrun_cnt, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_pwm_out", pwm_out, 0);
        check("rst_hold_synth_ready", bus.synth_ready, 0);
        rst_n = 1'b1;
    endtask

    task automatic push_code(input int c);
        bus.code        = W'(c);
        bus.synth_valid = 1'b1;
        tick();
        bus.synth_valid = 1'b0;
    endtask

    task automatic skip_to_start();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (period_start !== 1'b1 && n < 3 * P);
        check("next_start", period_start, 1);
    endtask

    task automatic goto_phase(input int target);
        int n;
        n = 0;
        while (phase != target && n < 2 * P) begin
            tick();
            n++;
        end
        check("goto_phase", n < 2 * P, 1);
    endtask

    // Counts pwm_out highs across one full output period starting at a period_start sample.
    task automatic measure(input string tag);
        int h, want, starts;
        want   = act;
        h      = 0;
        starts = 0;
        check({tag, "_aligned"}, period_start, 1);
        for (int i = 0; i < P; i++) begin
            h += int'(pwm_out);
            if (period_start === 1'b1) starts++;
            tick();
        end
        check(tag, h, want);
        check({tag, "_starts"}, starts, 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2, c3, n;
        bus.code        = '0;
        bus.synth_valid = 1'b0;
        model_reset();

        apply_reset();
        tick();
        enable = 1'b1;
        tick();

        // No samples: mid-scale duty, underrun after the first wrap
        measure("duty_reset_512");
        check("underrun_after_wrap", underrun, 1);
        measure("duty_hold_512");

        // Back-to-back pushes fill the buffer
        push_code(100);
        push_code(900);
        check("full_level", buf_level, 2);
        check("full_ready", bus.synth_ready, 0);
        skip_to_start();
        measure("duty_100");
        measure("duty_900");

        // Extremes
        push_code(0);
        push_code(1023);
        skip_to_start();
        measure("duty_0");
        measure("duty_1023");

        // Push and pop on the same edge at level 1
        c1 = $urandom_range(0, P - 1);
        c2 = $urandom_range(0, P - 1);
        c3 = $urandom_range(0, P - 1);
        push_code(c1);
        push_code(c2);
        skip_to_start();
        check("simul_level_before", buf_level, 1);
        goto_phase(P - 1);
        push_code(c3);
        check("simul_level_after", buf_level, 1);
        skip_to_start();
        measure("simul_head");
        measure("simul_pushed");

        // Randomized pushes at random phases
        repeat (4) begin
            repeat ($urandom_range(1, 300)) tick();
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) push_code($urandom_range(0, P - 1));
            skip_to_start();
            measure("rand_duty");
        end

        // Enable falling mid-period, then restart with the retained code
        push_code($urandom_range(0, P - 1));
        skip_to_start();
        repeat (50) tick();
        enable = 1'b0;
        tick();
        check("pwm_off_after_disable", pwm_out, 0);
        repeat (10) tick();
        check("pwm_off_idle", pwm_out, 0);
        enable = 1'b1;
        tick();
        measure("reenable_duty");

        // Drain, clear, then starve for five periods
        measure("drain_a");
        measure("drain_b");
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("ur_cleared", underrun, 0);
        skip_to_start();
        repeat (4) measure("starve_duty");
        check("ur_starved", underrun, 1);
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        check("urcnt_starve5", underrun_cnt, 5);
`endif
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("ur_clr_pulse", underrun, 0);
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        check("urcnt_clr_pulse", underrun_cnt, 0);
`endif

        // Clear coinciding with an empty-buffer load: set wins
        goto_phase(P - 1);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("ur_set_wins", underrun, 1);
`ifdef PWM_DAC_UNDERRUN_CNT_EN
        check("urcnt_set_wins", underrun_cnt, 1);
`endif

        // Asynchronous reset mid-period with a full buffer
        skip_to_start();
        push_code($urandom_range(0, 200));
        push_code($urandom_range(0, P - 1));
        goto_phase(300);
        apply_reset();
        tick();
        check("post_reset_level", buf_level, 0);
        measure("post_reset_512");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
